// File: rtl/serial_out_sequencer.sv
// Descriptor FIFO plus frame sequencer feeding the multi-rate serial output stage.
// Frames are issued in write order with a start pulse; abort flushes and pulses stop.
module serial_out_sequencer #(
  parameter int DATA_BIT   = 16,
  parameter int DEPTH_LOG2 = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [DATA_BIT-1:0] i_wr_data,
  input  logic                i_wr_sel_freq,
  input  logic [1:0]          i_wr_idle_mode,
  input  logic                i_run,
  input  logic                i_abort,
  input  logic                i_done_tick,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_start,
  output logic                o_stop,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_sel_freq,
  output logic [1:0]          o_idle_mode,
  output logic                o_busy,
  output logic [7:0]          o_frame_cnt,
  output logic                o_overflow
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int PTR_W   = DEPTH_LOG2 + 1;
  localparam int ENTRY_W = DATA_BIT + 3;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t              state_q;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic                start_q, stop_q, busy_q, overflow_q, sel_freq_q;
  logic [DATA_BIT-1:0] data_q;
  logic [1:0]          idle_mode_q;
  logic [7:0]          frame_cnt_q;
  logic                push_s, pop_s;
  logic [ENTRY_W-1:0]  head_s;

  // Flags are sampled pre-edge, so a write while full is dropped even if a pop happens now.
  assign push_s = i_wr_en && !full_q && !i_abort;
  assign pop_s  = (state_q == ST_IDLE) && i_run && !empty_q && !i_abort;
  assign head_s = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Next pointer values and the flags derived from them.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PTR_W-1] != rd_ptr_d[PTR_W-1]) &&
              (wr_ptr_d[PTR_W-2:0] == rd_ptr_d[PTR_W-2:0]);
  end

  // FIFO pointers and registered occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Descriptor storage, packed as {sel_freq, idle_mode, data}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {i_wr_sel_freq, i_wr_idle_mode, i_wr_data};
    end
  end

  // Frame sequencer with registered strobes, frame outputs and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
      data_q      <= '0;
      sel_freq_q  <= 1'b0;
      idle_mode_q <= 2'd0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= i_abort;
      if (i_abort) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        overflow_q  <= 1'b0;
        frame_cnt_q <= 8'd0;
      end else begin
        if (i_wr_en && full_q) begin
          overflow_q <= 1'b1;
        end
        case (state_q)
          ST_IDLE: begin
            if (pop_s) begin
              data_q      <= head_s[DATA_BIT-1:0];
              idle_mode_q <= head_s[DATA_BIT+1:DATA_BIT];
              sel_freq_q  <= head_s[DATA_BIT+2];
              busy_q      <= 1'b1;
              state_q     <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            start_q <= 1'b1;
            state_q <= ST_START;
          end
          ST_START: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (i_done_tick) begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              if (GAP_CYCLES > 0) begin
                gap_cnt_q <= '0;
                state_q   <= ST_GAP;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_ONE;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_start     = start_q;
  assign o_stop      = stop_q;
  assign o_data      = data_q;
  assign o_sel_freq  = sel_freq_q;
  assign o_idle_mode = idle_mode_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_serial_out_sequencer.sv
// Drives a no-gap and a 4-cycle-gap sequencer with shared stimulus and checks
// both against a timeline model of frame issue, done, gap and abort events.
module tb_serial_out_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_sel, run, abort, done;
  logic [15:0] wr_data;
  logic [1:0]  wr_mode;

  logic [1:0]       d_full, d_empty, d_start, d_stop, d_busy, d_ovf, d_sel;
  logic [1:0][15:0] d_data;
  logic [1:0][1:0]  d_mode;
  logic [1:0][7:0]  d_frames;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: FIFO contents as a circular list plus event timestamps per instance.
  logic [18:0] m_buf [2][4];
  int          m_cnt [2];
  int          m_hd [2];
  int          m_start_at [2];
  int          m_free_at [2];
  bit          m_wait [2];
  bit          m_ovf [2];
  bit          m_stop [2];
  logic [7:0]  m_frames [2];
  logic [18:0] m_out [2];

  always #5 clk = ~clk;

  serial_out_sequencer #(.DATA_BIT(16), .DEPTH_LOG2(2), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_wr_sel_freq(wr_sel),
    .i_wr_idle_mode(wr_mode), .i_run(run), .i_abort(abort), .i_done_tick(done),
    .o_full(d_full[0]), .o_empty(d_empty[0]), .o_start(d_start[0]), .o_stop(d_stop[0]),
    .o_data(d_data[0]), .o_sel_freq(d_sel[0]), .o_idle_mode(d_mode[0]), .o_busy(d_busy[0]),
    .o_frame_cnt(d_frames[0]), .o_overflow(d_ovf[0]));

  serial_out_sequencer #(.DATA_BIT(16), .DEPTH_LOG2(2), .GAP_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_wr_sel_freq(wr_sel),
    .i_wr_idle_mode(wr_mode), .i_run(run), .i_abort(abort), .i_done_tick(done),
    .o_full(d_full[1]), .o_empty(d_empty[1]), .o_start(d_start[1]), .o_stop(d_stop[1]),
    .o_data(d_data[1]), .o_sel_freq(d_sel[1]), .o_idle_mode(d_mode[1]), .o_busy(d_busy[1]),
    .o_frame_cnt(d_frames[1]), .o_overflow(d_ovf[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_hd[k] = 0; m_start_at[k] = -1; m_free_at[k] = 0;
      m_wait[k] = 1'b0; m_ovf[k] = 1'b0; m_stop[k] = 1'b0;
      m_frames[k] = 8'd0; m_out[k] = 19'd0;
    end
  endtask

  // Advance the model across the edge that ends cycle c, using this cycle's inputs.
  task automatic model_step(input int c);
    for (int k = 0; k < 2; k++) begin
      int  gap;
      int  cnt_pre;
      int  wpos;
      bit  idle;
      gap     = (k == 0) ? 0 : 4;
      cnt_pre = m_cnt[k];
      wpos    = (m_hd[k] + cnt_pre) % 4;
      idle    = !m_wait[k] && (m_start_at[k] < 0) && (c >= m_free_at[k]);
      m_stop[k] = abort;
      if (abort) begin
        m_cnt[k] = 0; m_hd[k] = 0; m_start_at[k] = -1; m_wait[k] = 1'b0;
        m_free_at[k] = c + 1; m_frames[k] = 8'd0; m_ovf[k] = 1'b0;
      end else begin
        if (m_wait[k] && done) begin
          m_frames[k]  = m_frames[k] + 8'd1;
          m_wait[k]    = 1'b0;
          m_free_at[k] = c + 1 + gap;
        end
        if (c == m_start_at[k]) begin
          m_wait[k]     = 1'b1;
          m_start_at[k] = -1;
        end
        if (idle && run && cnt_pre > 0) begin
          m_out[k]      = m_buf[k][m_hd[k]];
          m_hd[k]       = (m_hd[k] + 1) % 4;
          m_cnt[k]      = m_cnt[k] - 1;
          m_start_at[k] = c + 2;
        end
        if (wr_en) begin
          if (cnt_pre == 4) begin
            m_ovf[k] = 1'b1;
          end else begin
            m_buf[k][wpos] = {wr_sel, wr_mode, wr_data};
            m_cnt[k]       = m_cnt[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      bit exp_busy;
      exp_busy = m_wait[k] || (m_start_at[k] >= 0) || (cyc < m_free_at[k]);
      check($sformatf("u%0d.full", k),   32'(d_full[k]),   32'(m_cnt[k] == 4));
      check($sformatf("u%0d.empty", k),  32'(d_empty[k]),  32'(m_cnt[k] == 0));
      check($sformatf("u%0d.start", k),  32'(d_start[k]),  32'(m_start_at[k] == cyc));
      check($sformatf("u%0d.stop", k),   32'(d_stop[k]),   32'(m_stop[k]));
      check($sformatf("u%0d.busy", k),   32'(d_busy[k]),   32'(exp_busy));
      check($sformatf("u%0d.frames", k), 32'(d_frames[k]), 32'(m_frames[k]));
      check($sformatf("u%0d.ovf", k),    32'(d_ovf[k]),    32'(m_ovf[k]));
      check($sformatf("u%0d.frame_out", k), 32'({d_sel[k], d_mode[k], d_data[k]}), 32'(m_out[k]));
    end
  endtask

  task automatic check_reset_values(input string when);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.u%0d.outs", when, k),
            32'({d_full[k], d_empty[k], d_start[k], d_stop[k], d_busy[k], d_ovf[k]}), 32'(6'b010000));
      check($sformatf("%s.u%0d.frames", when, k), 32'(d_frames[k]), 32'd0);
      check($sformatf("%s.u%0d.frame_out", when, k),
            32'({d_sel[k], d_mode[k], d_data[k]}), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(cyc);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input logic [15:0] d, input logic s, input logic [1:0] m);
    wr_en = 1'b1; wr_data = d; wr_sel = s; wr_mode = m;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input int done_period);
    for (int i = 0; i < n; i++) begin
      done = (done_period > 0) && (i % done_period == done_period - 1);
      tick();
    end
    done = 1'b0;
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 16'd0; wr_sel = 1'b0; wr_mode = 2'd0;
    run = 1'b0; abort = 1'b0; done = 1'b0;
    model_reset();
    #3 check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    // Three frames in order, then run.
    push(16'hA5A5, 1'b0, 2'd0);
    push(16'h1234, 1'b1, 2'd1);
    push(16'hFFFF, 1'b0, 2'd2);
    run = 1'b1;
    idle_cycles(80, 5);

    // Five pushes into a four-deep FIFO with run low.
    run = 1'b0;
    for (int i = 0; i < 5; i++) push(16'(16'h0100 + i), i[0], 2'(i));
    idle_cycles(3, 0);
    run = 1'b1;
    idle_cycles(100, 4);

    // Stray done ticks while idle, data queued but run low.
    run = 1'b0;
    push(16'h0BAD, 1'b1, 2'd3);
    push(16'h0C0D, 1'b0, 2'd1);
    idle_cycles(10, 2);
    run = 1'b1;
    idle_cycles(60, 6);

    // Abort while waiting with entries queued.
    push(16'h1111, 1'b0, 2'd0);
    push(16'h2222, 1'b1, 2'd1);
    push(16'h3333, 1'b0, 2'd2);
    idle_cycles(4, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    idle_cycles(20, 3);

    // Reset mid-wait, then nothing issues until a new push.
    push(16'h4444, 1'b1, 2'd3);
    push(16'h5555, 1'b0, 2'd0);
    idle_cycles(5, 0);
    mid_reset();
    idle_cycles(10, 3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) run = ($urandom_range(0, 4) != 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = 16'($urandom);
      wr_sel  = 1'($urandom);
      wr_mode = 2'($urandom);
      abort   = ($urandom_range(0, 149) == 0);
      done    = ($urandom_range(0, 4) == 0);
      if (i == 1500) mid_reset();
      tick();
    end
    wr_en = 1'b0; abort = 1'b0; done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
